wide_add_sequencer: RTL and testbench
=====================================

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 The block SHALL have the parameter NUM_CHUNKS, default 4, giving the number of 16-bit chunks; legal values are 2..16; W = 16*NUM_CHUNKS.
REQ-002 One clock; reset is asynchronous and active-high; port clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  operand request.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry-in to chunk 0.
REQ-009 op  input  1  0 = add, 1 = subtract; present only with SUB_EN.
REQ-010 sum  output  W  registered result.
REQ-011 cout  output  1  carry out of the most significant chunk.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 Datapath: exactly one ripple_carry_16_bit instance, reused once per chunk; no other adder in the block.
REQ-015 FSM states: IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 IDLE: when in_valid=1, the edge registers a, b, cin (and op), clears chunk index k, sets carry_reg=cin, and moves to CALC.
REQ-017 CALC, each edge: adder inputs are a[16k+15:16k], b chunk and carry_reg; sum[16k+15:16k] is stored; carry_reg takes the adder cout; k increments.
REQ-018 CALC: on the edge that stores chunk NUM_CHUNKS-1, cout takes the final carry and the FSM moves to DONE.
REQ-019 Latency: out_valid is high after exactly NUM_CHUNKS rising edges following the accepting edge.
REQ-020 DONE: sum and cout are held stable; the FSM moves to IDLE on an edge with out_ready=1.
REQ-021 DONE: it stays in DONE indefinitely while out_ready=0.
REQ-022 in_valid is ignored in CALC and DONE; operand input changes after acceptance do not affect the result.
REQ-023 No back-to-back operation: in_ready rises one cycle after the result handshake.
REQ-024 sum is not cleared between operations; upper chunks show stale data until they are overwritten, and only out_valid qualifies sum.
REQ-025 Arithmetic is unsigned modulo 2^W; {cout,sum} = a + b + cin.

Reset
REQ-026 When rst=1, regardless of clk: state=IDLE, k=0, carry_reg=0, sum=0, cout=0, out_valid=0, in_ready=1.
REQ-027 Reset during CALC or DONE aborts the operation; the partial result is discarded, and no out_valid pulse occurs.
REQ-028 After rst falls, a request is accepted on the first edge with in_valid=1.

Configuration
REQ-029 Macro SUB_EN defined: op port exists; when op=1 at acceptance, the registered B is ~b and the effective carry-in is 1 (cin ignored), so that {cout,sum} = a - b with cout=1 meaning no borrow.
REQ-030 SUB_EN undefined: no op port, no inversion logic, and the behaviour is add-only as in REQ-025.

Verification
REQ-031 NUM_CHUNKS=4: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0, cout=1, out_valid exactly 4 edges after acceptance.
REQ-032 a=0x0000_0000_0000_FFFF, b=0, cin=1 -> sum=0x0000_0000_0001_0000, cout=0, proving inter-chunk carry.
REQ-033 Result ready with out_ready=0 for 10 cycles -> sum/cout stable, out_valid=1, in_ready=0; then out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 Assert rst asynchronously after the 2nd CALC edge -> out_valid=0, in_ready=1, sum=0 immediately; no late out_valid pulse.
REQ-035 SUB_EN: op=1, a=5, b=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0; op=1, a=7, b=5 -> sum=2, cout=1.
REQ-036 in_valid held high with changing a/b during CALC -> result matches the first accepted operands only, with exactly one result per acceptance.

Source files
------------

// File: rtl/wide_add_sequencer_if.sv
// Handshake and operand/result bus for wide_add_sequencer.
// The op signal exists only when SUB_EN is defined.
interface wide_add_sequencer_if #(
    parameter int NUM_CHUNKS = 4
);
    localparam int W = 16 * NUM_CHUNKS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SUB_EN
    logic         op;
`endif
    logic [W-1:0] sum;
    logic         cout;
    logic         out_valid;
    logic         out_ready;

`ifdef SUB_EN
    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, sum, cout, out_valid
    );
    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, sum, cout, out_valid
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, sum, cout, out_valid
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, sum, cout, out_valid
    );
`endif
endinterface

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: one 16-bit ripple-carry adder reused per chunk, LSB chunk first.
// Optional macro SUB_EN adds an op input selecting subtraction (a - b).

module ripple_carry_16_bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [16:0] c_s;

    // Bitwise full-adder chain.
    always_comb begin
        c_s    = 17'd0;
        sum    = 16'd0;
        c_s[0] = cin;
        for (int i = 0; i < 16; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
        end
        cout = c_s[16];
    end
endmodule

module wide_add_sequencer #(
    parameter int NUM_CHUNKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    wide_add_sequencer_if.slave   bus
);
    localparam int       W    = 16 * NUM_CHUNKS;
    localparam logic [3:0] LAST = 4'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   k_q, k_d;
    logic         carry_q, carry_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] sum_q, sum_d;
    logic         cout_q, cout_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;

    logic [7:0]   shift_s;
    logic [W-1:0] a_shift_s;
    logic [W-1:0] b_shift_s;
    logic [W-1:0] chunk_mask_s;
    logic [W-1:0] chunk_sum_s;
    logic [15:0]  add_sum_s;
    logic         add_cout_s;

    // Select the current chunk of the registered operands.
    always_comb begin
        shift_s      = {k_q, 4'b0000};
        a_shift_s    = a_q >> shift_s;
        b_shift_s    = b_q >> shift_s;
        chunk_mask_s = {{(W-16){1'b0}}, 16'hFFFF} << shift_s;
        chunk_sum_s  = {{(W-16){1'b0}}, add_sum_s} << shift_s;
    end

    ripple_carry_16_bit u_adder (
        .a    (a_shift_s[15:0]),
        .b    (b_shift_s[15:0]),
        .cin  (carry_q),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d        = bus.a;
                    k_d        = 4'd0;
                    state_d    = CALC;
                    in_ready_d = 1'b0;
`ifdef SUB_EN
                    // Two's-complement subtract: invert B and force carry-in.
                    if (bus.op) begin
                        b_d     = ~bus.b;
                        carry_d = 1'b1;
                    end else begin
                        b_d     = bus.b;
                        carry_d = bus.cin;
                    end
`else
                    b_d     = bus.b;
                    carry_d = bus.cin;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                sum_d   = (sum_q & ~chunk_mask_s) | chunk_sum_s;
                carry_d = add_cout_s;
                k_d     = k_q + 4'd1;
                if (k_q == LAST) begin
                    cout_d      = add_cout_s;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 4'd0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with NUM_CHUNKS=4; SUB_EN vectors run when the macro is defined.
module tb_wide_add_sequencer;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    wide_add_sequencer_if #(.NUM_CHUNKS(N)) bus ();

    wide_add_sequencer #(.NUM_CHUNKS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        op;
        logic [63:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v, input int hold, input bit scramble);
        int cnt;
        cnt = 0;
        @(negedge clk);
        for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
        chk("ready_before", 64'(bus.in_ready), 64'd1);
        bus.a = v.a; bus.b = v.b; bus.cin = v.cin; bus.in_valid = 1'b1;
`ifdef SUB_EN
        bus.op = v.op;
`endif
        @(posedge clk); #1;
        chk("accept_busy", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (scramble) begin
                bus.a = ~bus.a ^ 64'(i);
                bus.b = bus.b + 64'h0001_0001_0001_0001;
                bus.cin = ~bus.cin;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
            if (bus.out_valid) break;
        end
        chk("latency", 64'(cnt), 64'(N));
        chk("sum", bus.sum, v.exp_sum);
        chk("cout", 64'(bus.cout), 64'(v.exp_cout));
        chk("done_busy", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_sum", bus.sum, v.exp_sum);
            chk("hold_cout", 64'(bus.cout), 64'(v.exp_cout));
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_ready", 64'(bus.in_ready), 64'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk); #1;
        chk("handshake_ready", 64'(bus.in_ready), 64'd1);
        chk("handshake_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        if (scramble) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                chk("single_result", 64'(bus.out_valid), 64'd0);
            end
        end
    endtask

    vec_t vecs[6];
    vec_t v;

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
`ifdef SUB_EN
        bus.op = 1'b0;
`endif
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1};
        vecs[1] = '{64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
        vecs[2] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'h1, 1'b1};
        vecs[4] = '{64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0001_0000_0000_0000, 1'b0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

        rst = 1'b1;
        #2;
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", bus.sum, 64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) do_op(vecs[i], 0, 1'b0);

        // Consumer stalls for 10 cycles.
        do_op(vecs[2], 10, 1'b0);

        // Operands and in_valid churn during CALC; only the first operands count.
        do_op(vecs[1], 0, 1'b1);

        // Abort after the second CALC edge.
        @(negedge clk);
        bus.a = 64'h0001_0001_0001_0001; bus.b = 64'h0; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_sum", bus.sum, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("no_late_valid", 64'(bus.out_valid), 64'd0);
        end

        // First request after reset release.
        do_op(vecs[4], 0, 1'b0);

`ifdef SUB_EN
        v = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        do_op(v, 0, 1'b0);
        v = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1};
        do_op(v, 0, 1'b0);
`else
        v = vecs[0];
        do_op(v, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
